// File: rtl/mssd_tx.sv
// Serial frame transmitter: idle-high, start, 2-bit port, 6-bit length, payload, stop.
// Optional even-parity bit before stop when MSSD_TX_PARITY_EN is defined.
module mssd_tx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_portSel,
    input  logic [5:0] i_len,
    input  logic       i_dIn,
    output logic       o_dReq,
    output logic       o_sOut,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PORT,
        S_LEN,
        S_DATA,
        S_STOP
`ifdef MSSD_TX_PARITY_EN
        , S_PAR
`endif
    } state_t;

    state_t     r_state, w_next;
    logic [7:0] r_sh, w_sh_nxt;
    logic [5:0] r_len;
    logic [5:0] r_rem, w_rem_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_sout, w_sout_nxt;
    logic       w_cap;
    logic       w_dreq;
`ifdef MSSD_TX_PARITY_EN
    logic       r_par;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_len   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_sout  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_sh    <= w_sh_nxt;
            r_rem   <= w_rem_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sout  <= w_sout_nxt;
            if (w_cap)
                r_len <= i_len;
        end
    end

`ifdef MSSD_TX_PARITY_EN
    // Running XOR of every payload bit sampled; fresh for each frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_par <= 1'b0;
        else if (w_cap)
            r_par <= 1'b0;
        else if (w_dreq)
            r_par <= r_par ^ i_dIn;
    end
`endif

    // Header bits ride a shift register: r_sh[0] is the bit currently on the line.
    always_comb begin
        w_next     = r_state;
        w_sh_nxt   = r_sh;
        w_rem_nxt  = r_rem;
        w_cnt_nxt  = r_cnt;
        w_sout_nxt = r_sout;
        w_cap      = 1'b0;
        w_dreq     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sout_nxt = 1'b1;
                if (i_start) begin
                    w_cap      = 1'b1;
                    w_next     = S_START;
                    w_sout_nxt = 1'b0;
                    w_sh_nxt   = {i_len, i_portSel};
                end
            end
            S_START: begin
                w_next     = S_PORT;
                w_sout_nxt = r_sh[0];
                w_cnt_nxt  = 3'd0;
            end
            S_PORT: begin
                w_sout_nxt = r_sh[1];
                w_sh_nxt   = r_sh >> 1;
                if (r_cnt == 3'd1) begin
                    w_next    = S_LEN;
                    w_cnt_nxt = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            S_LEN: begin
                if (r_cnt == 3'd5) begin
                    if (r_len != 6'd0) begin
                        w_dreq     = 1'b1;
                        w_next     = S_DATA;
                        w_sout_nxt = i_dIn;
                        w_rem_nxt  = r_len;
                    end else begin
`ifdef MSSD_TX_PARITY_EN
                        w_next     = S_PAR;
                        w_sout_nxt = r_par;
`else
                        w_next     = S_STOP;
                        w_sout_nxt = 1'b1;
`endif
                    end
                end else begin
                    w_sout_nxt = r_sh[1];
                    w_sh_nxt   = r_sh >> 1;
                    w_cnt_nxt  = r_cnt + 3'd1;
                end
            end
            S_DATA: begin
                if (r_rem == 6'd1) begin
`ifdef MSSD_TX_PARITY_EN
                    w_next     = S_PAR;
                    w_sout_nxt = r_par;
`else
                    w_next     = S_STOP;
                    w_sout_nxt = 1'b1;
`endif
                end else begin
                    w_dreq     = 1'b1;
                    w_sout_nxt = i_dIn;
                    w_rem_nxt  = r_rem - 6'd1;
                end
            end
`ifdef MSSD_TX_PARITY_EN
            S_PAR: begin
                w_next     = S_STOP;
                w_sout_nxt = 1'b1;
            end
`endif
            S_STOP: begin
                w_next     = S_IDLE;
                w_sout_nxt = 1'b1;
            end
            default: begin
                w_next     = S_IDLE;
                w_sout_nxt = 1'b1;
            end
        endcase
    end

    assign o_dReq = w_dreq;
    assign o_sOut = r_sout;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_STOP);

endmodule

// File: tb/tb_mssd_tx.sv
// Scoreboard bench for mssd_tx: expected line bits queued per frame, popped per cycle.
module tb_mssd_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] portSel = '0;
    logic [5:0] len = '0;
    logic       dIn = 1'b0;
    logic       dReq, sOut, busy, done;

    int tests = 0;
    int fails = 0;
    bit sb[$];

`ifdef MSSD_TX_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    mssd_tx dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_portSel(portSel),
        .i_len(len), .i_dIn(dIn), .o_dReq(dReq), .o_sOut(sOut),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [1:0] p, input logic [5:0] l, input logic [63:0] d);
        bit par = 1'b0;
        sb.push_back(1'b0);
        for (int i = 0; i < 2; i++) sb.push_back(p[i]);
        for (int i = 0; i < 6; i++) sb.push_back(l[i]);
        for (int i = 0; i < int'(l); i++) begin
            sb.push_back(d[i]);
            par ^= d[i];
        end
        if (PX == 1) sb.push_back(par);
        sb.push_back(1'b1);
    endtask

    task automatic send_frame(input string nm, input logic [1:0] p, input logic [5:0] l,
                              input logic [63:0] d);
        int n, bcnt, rcnt, dcnt, dat, dptr;
        bit exp;
        sb.delete();
        push_frame(p, l, d);
        n = sb.size();
        bcnt = 0; rcnt = 0; dcnt = 0; dat = -1; dptr = 0;
        @(negedge clk);
        start = 1'b1; portSel = p; len = l;
        @(negedge clk);
        start = 1'b0; portSel = ~p; len = ~l;
        for (int k = 0; k < n; k++) begin
            exp = sb.pop_front();
            tests++;
            if (sOut !== exp) begin
                fails++;
                $display("FAIL %s sOut bit %0d: got %b expected %b", nm, k, sOut, exp);
            end
            if (busy) bcnt++;
            if (done) begin dcnt++; dat = k; end
            if (dReq) begin
                rcnt++;
                dIn = d[dptr];
                dptr++;
            end else begin
                dIn = 1'b0;
            end
            @(negedge clk);
        end
        tests++;
        if (bcnt != n) begin
            fails++; $display("FAIL %s busy cycles: got %0d expected %0d", nm, bcnt, n);
        end
        tests++;
        if (rcnt != int'(l)) begin
            fails++; $display("FAIL %s dReq cycles: got %0d expected %0d", nm, rcnt, l);
        end
        tests++;
        if (dcnt != 1 || dat != n - 1) begin
            fails++; $display("FAIL %s done: got %0d pulses at %0d expected 1 at %0d", nm, dcnt, dat, n - 1);
        end
        tests++;
        if (busy !== 1'b0 || sOut !== 1'b1) begin
            fails++; $display("FAIL %s idle after: got busy=%b sOut=%b expected 0/1", nm, busy, sOut);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if ({sOut, busy, dReq, done} !== 4'b1000) begin
                fails++;
                $display("FAIL reset idle cyc %0d: got sOut/busy/dReq/done=%b expected 1000",
                         k, {sOut, busy, dReq, done});
            end
        end
    endtask

    task automatic test_frame();
        send_frame("p2_len6", 2'd2, 6'd6, 64'b001101);
    endtask

    task automatic test_len0();
        send_frame("p3_len0", 2'd3, 6'd0, 64'd0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++)
            send_frame("rand", 2'($urandom_range(3)), 6'($urandom_range(12, 1)),
                       {$urandom, $urandom});
        send_frame("len63", 2'd1, 6'd63, {$urandom, $urandom});
    endtask

    task automatic test_back_to_back();
        int flen, n, dptr;
        bit exp;
        logic [63:0] d = 64'b01;
        flen = 11 + PX;
        sb.delete();
        push_frame(2'd1, 6'd1, 64'd1);
        sb.push_back(1'b1);
        push_frame(2'd1, 6'd1, 64'd0);
        n = sb.size();
        dptr = 0;
        @(negedge clk);
        start = 1'b1; portSel = 2'd1; len = 6'd1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k == flen) begin portSel = 2'd1; len = 6'd1; end
            else begin portSel = 2'd2; len = 6'd5; end
            exp = sb.pop_front();
            tests++;
            if (sOut !== exp) begin
                fails++;
                $display("FAIL b2b sOut bit %0d: got %b expected %b", k, sOut, exp);
            end
            if (dReq) begin dIn = d[dptr]; dptr++; end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || sOut !== 1'b1) begin
            fails++; $display("FAIL b2b end idle: got busy=%b sOut=%b expected 0/1", busy, sOut);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; portSel = 2'd1; len = 6'd6;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 11; k++) begin
            dIn = dReq ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        tests++;
        if (busy !== 1'b1 || dReq !== 1'b1) begin
            fails++; $display("FAIL mid pre-reset: got busy=%b dReq=%b expected 1/1", busy, dReq);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({sOut, busy, dReq, done} !== 4'b1000) begin
            fails++;
            $display("FAIL mid reset async: got sOut/busy/dReq/done=%b expected 1000",
                     {sOut, busy, dReq, done});
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame("after_reset", 2'd2, 6'd6, 64'b001101);
    endtask

`ifdef MSSD_TX_PARITY_EN
    task automatic test_parity();
        send_frame("parity", 2'd0, 6'd3, 64'b111);
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_len0();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef MSSD_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
